board_move_selector: RTL and testbench

//  Sits downstream of the mouse controller and alongside the board renderer.

---
 rtl/board_pkg.sv | 15 +
 rtl/pos_to_square.sv | 34 +++
 rtl/board_move_selector.sv | 139 +++++++++++++
 tb/tb_board_move_selector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Board geometry and move-selector state encoding, shared with the board renderer.
package board_pkg;

    localparam int unsigned BOARD_X0 = 17;
    localparam int unsigned BOARD_Y0 = 0;
    localparam int unsigned SQ_LOG2  = 3;
    localparam int unsigned NSQ      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SRC   = 2'd1,
        ST_OFFER = 2'd2
    } state_e;

endpackage

// File: rtl/pos_to_square.sv
// Combinational pixel-to-square decode; also used by the renderer for highlight matching.
module pos_to_square #(
    parameter int unsigned X0       = board_pkg::BOARD_X0,
    parameter int unsigned Y0       = board_pkg::BOARD_Y0,
    parameter int unsigned SQ_SHIFT = board_pkg::SQ_LOG2,
    parameter int unsigned N_SQ     = board_pkg::NSQ
) (
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    output logic        on,
    output logic [2:0]  col,
    output logic [2:0]  row
);

    localparam logic [12:0] X0_W = 13'(X0);
    localparam logic [12:0] Y0_W = 13'(Y0);
    localparam logic [11:0] SPAN = 12'(N_SQ << SQ_SHIFT);

    logic [12:0] dx_ext;
    logic [12:0] dy_ext;
    logic [11:0] dx;
    logic [11:0] dy;

    // Borrow out of the widened subtraction means the position is left of / above the origin.
    assign dx_ext = {1'b0, x_pos} - X0_W;
    assign dy_ext = {1'b0, y_pos} - Y0_W;
    assign dx     = dx_ext[11:0];
    assign dy     = dy_ext[11:0];

    assign on  = ~dx_ext[12] & ~dy_ext[12] & (dx < SPAN) & (dy < SPAN);
    assign col = 3'(dx >> SQ_SHIFT);
    assign row = 3'(dy >> SQ_SHIFT);

endmodule

// File: rtl/board_move_selector.sv
// Turns mouse position and left-button clicks into hover/selection squares and a
// two-click (source, destination) move offered over a valid/ready handshake.
module board_move_selector #(
    parameter int unsigned BOARD_X0 = board_pkg::BOARD_X0,
    parameter int unsigned BOARD_Y0 = board_pkg::BOARD_Y0,
    parameter int unsigned SQ_LOG2  = board_pkg::SQ_LOG2,
    parameter int unsigned NSQ      = board_pkg::NSQ
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    input  logic        left,
    output logic        hover_on,
    output logic [2:0]  hover_col,
    output logic [2:0]  hover_row,
    output logic        sel_valid,
    output logic [2:0]  sel_col,
    output logic [2:0]  sel_row,
    output logic        move_valid,
    output logic [5:0]  move_src,
    output logic [5:0]  move_dst,
    input  logic        move_ready
);

    import board_pkg::*;

    logic       dec_on;
    logic [2:0] dec_col;
    logic [2:0] dec_row;
    logic       click;

    logic       left_q;
    logic       hover_on_q;
    logic [2:0] hover_col_q, hover_row_q;
    state_e     state_q, state_d;
    logic       sel_valid_q, sel_valid_d;
    logic [2:0] sel_col_q, sel_col_d;
    logic [2:0] sel_row_q, sel_row_d;
    logic       move_valid_q, move_valid_d;
    logic [5:0] move_src_q, move_src_d;
    logic [5:0] move_dst_q, move_dst_d;

    pos_to_square #(
        .X0       (BOARD_X0),
        .Y0       (BOARD_Y0),
        .SQ_SHIFT (SQ_LOG2),
        .N_SQ     (NSQ)
    ) u_decode (
        .x_pos (x_pos),
        .y_pos (y_pos),
        .on    (dec_on),
        .col   (dec_col),
        .row   (dec_row)
    );

    assign click = left & ~left_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            left_q       <= 1'b0;
            hover_on_q   <= 1'b0;
            hover_col_q  <= '0;
            hover_row_q  <= '0;
            state_q      <= ST_IDLE;
            sel_valid_q  <= 1'b0;
            sel_col_q    <= '0;
            sel_row_q    <= '0;
            move_valid_q <= 1'b0;
            move_src_q   <= '0;
            move_dst_q   <= '0;
        end else begin
            left_q       <= left;
            hover_on_q   <= dec_on;
            hover_col_q  <= dec_on ? dec_col : '0;
            hover_row_q  <= dec_on ? dec_row : '0;
            state_q      <= state_d;
            sel_valid_q  <= sel_valid_d;
            sel_col_q    <= sel_col_d;
            sel_row_q    <= sel_row_d;
            move_valid_q <= move_valid_d;
            move_src_q   <= move_src_d;
            move_dst_q   <= move_dst_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_valid_d  = sel_valid_q;
        sel_col_d    = sel_col_q;
        sel_row_d    = sel_row_q;
        move_valid_d = move_valid_q;
        move_src_d   = move_src_q;
        move_dst_d   = move_dst_q;
        case (state_q)
            ST_IDLE: begin
                if (click && dec_on) begin
                    sel_col_d   = dec_col;
                    sel_row_d   = dec_row;
                    sel_valid_d = 1'b1;
                    state_d     = ST_SRC;
                end
            end
            ST_SRC: begin
                // Any second click either completes the move or cancels the selection.
                if (click) begin
                    if (dec_on && ({dec_row, dec_col} != {sel_row_q, sel_col_q})) begin
                        move_src_d   = {sel_row_q, sel_col_q};
                        move_dst_d   = {dec_row, dec_col};
                        move_valid_d = 1'b1;
                        state_d      = ST_OFFER;
                    end else begin
                        sel_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
            end
            ST_OFFER: begin
                if (move_ready) begin
                    move_valid_d = 1'b0;
                    sel_valid_d  = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign hover_on   = hover_on_q;
    assign hover_col  = hover_col_q;
    assign hover_row  = hover_row_q;
    assign sel_valid  = sel_valid_q;
    assign sel_col    = sel_col_q;
    assign sel_row    = sel_row_q;
    assign move_valid = move_valid_q;
    assign move_src   = move_src_q;
    assign move_dst   = move_dst_q;

endmodule

// File: tb/tb_board_move_selector.sv
// Bench for board_move_selector: directed clicks, with selections and moves
// checked by a negedge monitor against queues filled by the stimulus.
module tb_board_move_selector;

    typedef struct packed {
        logic [5:0] src;
        logic [5:0] dst;
    } mv_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] x_pos = '0;
    logic [11:0] y_pos = '0;
    logic        left = 1'b0;
    logic        move_ready = 1'b0;
    logic        hover_on, sel_valid, move_valid;
    logic [2:0]  hover_col, hover_row, sel_col, sel_row;
    logic [5:0]  move_src, move_dst;

    int tests = 0;
    int fails = 0;
    int mv_cycles = 0;
    logic sel_prev = 1'b0;
    logic [5:0] sel_exp_q[$];
    mv_t        mv_exp_q[$];

    board_move_selector dut (
        .clock      (clock),
        .reset      (reset),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .left       (left),
        .hover_on   (hover_on),
        .hover_col  (hover_col),
        .hover_row  (hover_row),
        .sel_valid  (sel_valid),
        .sel_col    (sel_col),
        .sel_row    (sel_row),
        .move_valid (move_valid),
        .move_src   (move_src),
        .move_dst   (move_dst),
        .move_ready (move_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_pos(input int x, input int y);
        x_pos = 12'(x);
        y_pos = 12'(y);
    endtask

    task automatic click(input int x, input int y);
        set_pos(x, y);
        left = 1'b1;
        tick();
        left = 1'b0;
        tick();
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (sel_valid && !sel_prev) begin
                if (sel_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sel_unexpected: got %o, expected no selection", {sel_row, sel_col});
                end else begin
                    check("sel_square", {26'd0, sel_row, sel_col}, {26'd0, sel_exp_q[0]});
                    void'(sel_exp_q.pop_front());
                end
            end
            if (move_valid) begin
                mv_cycles++;
                if (mv_exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL move_unexpected: got %o->%o, expected no move", move_src, move_dst);
                end else begin
                    check("move_src", {26'd0, move_src}, {26'd0, mv_exp_q[0].src});
                    check("move_dst", {26'd0, move_dst}, {26'd0, mv_exp_q[0].dst});
                    if (move_ready) void'(mv_exp_q.pop_front());
                end
            end
        end
        sel_prev = sel_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_hover_on", {31'd0, hover_on}, 0);
        check("rst_sel_valid", {31'd0, sel_valid}, 0);
        check("rst_move_valid", {31'd0, move_valid}, 0);
        check("rst_move_bits", {20'd0, move_src, move_dst}, 0);
        tick();
        reset = 1'b0;
        tick();

        // Hover decode, 1-cycle latency
        set_pos(16, 5);  tick();
        check("hover_x16_off", {31'd0, hover_on}, 0);
        set_pos(17, 0);
        check("hover_latency_on", {31'd0, hover_on}, 0);
        tick();
        check("hover_x17", {25'd0, hover_on, hover_row, hover_col}, {25'd0, 1'b1, 3'd0, 3'd0});
        set_pos(80, 63); tick();
        check("hover_x80_y63", {25'd0, hover_on, hover_row, hover_col}, {25'd0, 1'b1, 3'd7, 3'd7});
        set_pos(81, 63);
        check("hover_latency_off", {31'd0, hover_on}, 1);
        tick();
        check("hover_x81_off", {25'd0, hover_on, hover_row, hover_col}, 0);

        // Basic move with ready tied high
        move_ready = 1'b1;
        sel_exp_q.push_back(6'o00);
        click(20, 3);
        check("basic_sel_valid", {31'd0, sel_valid}, 1);
        mv_cycles = 0;
        mv_exp_q.push_back('{src: 6'o00, dst: 6'o55});
        click(60, 40);
        tick();
        check("basic_move_cycles", mv_cycles, 1);
        check("basic_sel_cleared", {31'd0, sel_valid}, 0);

        // Cancel: same square, then off-board
        mv_cycles = 0;
        sel_exp_q.push_back(6'o00);
        click(20, 3);
        click(22, 6);
        check("cancel_same_sel", {31'd0, sel_valid}, 0);
        sel_exp_q.push_back(6'o00);
        click(20, 3);
        click(5, 5);
        tick();
        check("cancel_off_sel", {31'd0, sel_valid}, 0);
        check("cancel_no_move", mv_cycles, 0);

        // Backpressure with clicks during the offer, including one in the accept cycle
        move_ready = 1'b0;
        sel_exp_q.push_back(6'o11);
        click(30, 10);
        mv_exp_q.push_back('{src: 6'o11, dst: 6'o76});
        click(70, 60);
        click(20, 3);
        click(5, 5);
        repeat (6) tick();
        check("bp_still_valid", {31'd0, move_valid}, 1);
        set_pos(40, 40);
        left = 1'b1;
        move_ready = 1'b1;
        tick();
        left = 1'b0;
        tick();
        check("bp_accept_valid", {31'd0, move_valid}, 0);
        check("bp_accept_sel", {31'd0, sel_valid}, 0);
        sel_exp_q.push_back(6'o00);
        click(20, 3);
        check("bp_idle_src", {31'd0, sel_valid}, 1);
        click(5, 5);

        // Held button: one click only
        mv_cycles = 0;
        sel_exp_q.push_back(6'o23);
        set_pos(44, 20);
        left = 1'b1;
        repeat (1000) tick();
        left = 1'b0;
        tick();
        check("held_sel", {25'd0, sel_valid, sel_row, sel_col}, {25'd0, 1'b1, 3'd2, 3'd3});
        check("held_no_move", mv_cycles, 0);

        // Async reset during the offer
        move_ready = 1'b0;
        mv_exp_q.push_back('{src: 6'o23, dst: 6'o55});
        click(60, 40);
        tick();
        check("offer_before_reset", {31'd0, move_valid}, 1);
        #1 reset = 1'b1;
        #1;
        check("arst_move_valid", {31'd0, move_valid}, 0);
        check("arst_sel_valid", {31'd0, sel_valid}, 0);
        check("arst_hover", {25'd0, hover_on, hover_row, hover_col}, 0);
        check("arst_move_bits", {20'd0, move_src, move_dst}, 0);
        check("arst_sel_bits", {26'd0, sel_row, sel_col}, 0);
        if (mv_exp_q.size() != 0) void'(mv_exp_q.pop_front());
        tick();
        reset = 1'b0;
        tick();
        sel_exp_q.push_back(6'o00);
        click(20, 3);
        check("post_reset_src", {31'd0, sel_valid}, 1);
        check("post_reset_no_move", {31'd0, move_valid}, 0);
        tick();

        check("sel_queue_drained", sel_exp_q.size(), 0);
        check("move_queue_drained", mv_exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
